// File: rtl/keypad_event_fifo.sv
// Keypad event generator with typematic auto-repeat feeding a small
// first-word-fall-through queue that the CPU drains with pop.
module keypad_event_fifo #(
  parameter int          ADDR_W       = 3,
  parameter logic [23:0] REPEAT_DELAY = 24'd5000000,
  parameter logic [23:0] REPEAT_RATE  = 24'd1000000,
  parameter int          CNT_W        = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        keyCode,
  input  logic              ready,
  input  logic              pop,
  input  logic              clr_ovf,
  output logic [4:0]        data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam int             DEPTH       = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CNT_W-1:0] DELAY_LAST_C = CNT_W'(REPEAT_DELAY - 24'd1);
  localparam logic [CNT_W-1:0] RATE_LAST_C  = CNT_W'(REPEAT_RATE - 24'd1);
  localparam logic           DELAY_ON_C  = (REPEAT_DELAY != 24'd0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  state_t            state_r, state_nxt_s;
  logic              ready_d_r;
  logic [CNT_W-1:0]  timer_r, timer_nxt_s;
  logic [4:0]        held_code_r, held_code_nxt_s;
  logic              push_s;
  logic [4:0]        push_data_s;
  logic              press_s, code_valid_s, code_change_s;

  logic [4:0]        mem_r [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [ADDR_W:0]   count_r;
  logic              overflow_r;
  logic              do_pop_s, do_push_s, drop_s;

  assign press_s       = ready & ~ready_d_r;
  assign code_valid_s  = (keyCode[4:2] != 3'h7);
  assign code_change_s = ready & code_valid_s & (keyCode != held_code_r);

  // Event FSM: decides when to push and what code to push.
  always_comb begin
    state_nxt_s     = state_r;
    timer_nxt_s     = timer_r;
    held_code_nxt_s = held_code_r;
    push_s          = 1'b0;
    push_data_s     = held_code_r;
    case (state_r)
      IDLE: begin
        if (press_s && code_valid_s) begin
          push_s          = 1'b1;
          push_data_s     = keyCode;
          held_code_nxt_s = keyCode;
          timer_nxt_s     = '0;
          state_nxt_s     = HOLD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      HOLD, REPEAT: begin
        // Release beats any repeat due in the same cycle.
        if (!ready) begin
          state_nxt_s = IDLE;
          timer_nxt_s = '0;
        end else if (code_change_s) begin
          push_s          = 1'b1;
          push_data_s     = keyCode;
          held_code_nxt_s = keyCode;
          timer_nxt_s     = '0;
          state_nxt_s     = HOLD;
        end else if (state_r == HOLD && DELAY_ON_C && timer_r == DELAY_LAST_C) begin
          push_s      = 1'b1;
          timer_nxt_s = '0;
          state_nxt_s = REPEAT;
        end else if (state_r == REPEAT && timer_r == RATE_LAST_C) begin
          push_s      = 1'b1;
          timer_nxt_s = '0;
        end else begin
          timer_nxt_s = timer_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_nxt_s = IDLE;
        timer_nxt_s = '0;
      end
    endcase
  end

  // FSM state, repeat timer, held code and ready edge history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      timer_r     <= '0;
      held_code_r <= 5'h00;
      ready_d_r   <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      timer_r     <= timer_nxt_s;
      held_code_r <= held_code_nxt_s;
      ready_d_r   <= ready;
    end
  end

  // A pop frees a slot, so a push into a full queue still lands.
  assign do_pop_s  = pop & (count_r != '0);
  assign do_push_s = push_s & ((count_r != DEPTH_C) | do_pop_s);
  assign drop_s    = push_s & (count_r == DEPTH_C) & ~do_pop_s;

  // Queue storage, pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 5'h00;
      end
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data_s;
        wr_ptr_r        <= wr_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + {{ADDR_W{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{ADDR_W{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (clr_ovf) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  assign data     = mem_r[rd_ptr_r];
  assign empty    = (count_r == '0);
  assign full     = (count_r == DEPTH_C);
  assign count    = count_r;
  assign overflow = overflow_r;

endmodule

// File: doc/keypad_event_fifo.md
Name: keypad_event_fifo

Overview:
- Sits directly downstream of the matrix keypad scanner/debouncer. Consumes its 5-bit key code and its debounced ready level.
- Turns each press into a discrete key event, with optional typematic auto-repeat while the key is held.
- Queues events in a small first-word-fall-through FIFO, read by the CPU/display logic through a pop handshake.

Parameters:
- ADDR_W, 3, FIFO address width; depth = 2^ADDR_W entries.
- REPEAT_DELAY, 24'd5000000, cycles from the initial press event to the first repeat event; 0 disables auto-repeat.
- REPEAT_RATE, 24'd1000000, cycles between successive repeat events; must be >= 1.
- CNT_W, 24, width of the repeat timer.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- keyCode  input  5  scanner code: [1:0] column, [4:2] row; row value 3'h7 means invalid.
- ready  input  1  debounced "exactly one key down" level from the scanner.
- pop  input  1  consume the head entry; ignored when empty.
- clr_ovf  input  1  clears the overflow flag.
- data  output  5  head-of-queue key code; valid while empty=0.
- empty  output  1  queue empty.
- full  output  1  queue holds 2^ADDR_W entries.
- count  output  ADDR_W+1  number of queued entries.
- overflow  output  1  sticky flag; set when an event is dropped.

Behaviour:
- Reset (rst=1 at a posedge):
  - wr/rd pointers = 0, count = 0, empty = 1, full = 0, overflow = 0, data = 5'h00.
  - FSM returns to IDLE and the repeat timer = 0.
  - ready_d is preset to 1, so a key already held through reset produces no event until ready has gone low once.
- Press detect:
  - press = ready & ~ready_d, where ready_d is ready registered each cycle.
  - keyCode is sampled in that same cycle.
  - A code with keyCode[4:2]==3'h7 is never enqueued, and the FSM stays in IDLE.
- FSM states: IDLE, HOLD, REPEAT.
  - IDLE -> HOLD on a valid press: push code, latch it in held_code, timer = 0.
  - HOLD:
    - Timer increments each cycle.
    - When timer == REPEAT_DELAY-1 and REPEAT_DELAY != 0: push held_code, timer = 0, go to REPEAT.
    - With REPEAT_DELAY == 0, stay in HOLD until release.
  - REPEAT: timer increments; at timer == REPEAT_RATE-1, push held_code and reset timer = 0.
  - HOLD/REPEAT -> IDLE when ready == 0. Release takes priority over a repeat push in the same cycle, so no push occurs.
  - HOLD/REPEAT with ready == 1 and a valid keyCode != held_code: treat as a new press. Push the new code, latch it, timer = 0, go to HOLD.
- Push timing:
  - A push at posedge N is visible after N: count increments, empty deasserts, and data shows the entry if the queue was empty.
  - First repeat is REPEAT_DELAY cycles after the initial push; each later repeat is REPEAT_RATE cycles after the previous one.
- FIFO:
  - data is always mem[rd_ptr] (fall-through).
  - pop with empty=1 is ignored.
  - Pointers wrap modulo 2^ADDR_W.
  - Push with full=1 and no pop: the entry is dropped, overflow is set, and pointers/count are unchanged.
  - Push and pop in the same cycle with full=1: both happen, count unchanged, no overflow.
  - Push and pop in the same cycle with empty=1: push only, count = 1.
  - Push and pop on a non-empty, non-full queue: count unchanged.
- Overflow flag:
  - clr_ovf clears it.
  - If clr_ovf and a drop occur in the same cycle, set wins and overflow stays 1.
- Outputs: all registered except data, empty and full, which decode directly from registers. No combinational path from input to output.

Test Plan:
- Reset with ready held 1, then release rst: no push occurs. Drop ready for 1 cycle, raise it again with keyCode=5'b01010 -> count=1, data=5'h0A one cycle after the edge.
- Params ADDR_W=2, REPEAT_DELAY=8, REPEAT_RATE=4; hold keyCode=5'h07 for 20 cycles after the press -> pushes at relative cycles 0, 8, 12, 16, so count=4 and full=1. Cycle 20 push is dropped -> overflow=1.
- Queue full (4 entries); press key 5'h03 with pop=1 in the same cycle -> count stays 4, overflow stays 0. Then pop 4 times -> data sequence ends with 5'h03, empty=1, and a 5th pop is ignored with count=0.
- keyCode=5'b11101 (row 7) with ready rising -> no push, FSM stays IDLE, count=0.
- While holding 5'h04 in REPEAT, switch keyCode to 5'h09 with ready still 1 -> 5'h09 is pushed immediately. The next repeat of 5'h09 arrives 8 cycles later; no further 5'h04 entries.
- rst asserted mid-REPEAT with 3 entries queued -> next cycle count=0, empty=1, overflow=0. With ready still 1 after rst deasserts, no event occurs until ready falls and rises again.
